alu_control_fsm: RTL and testbench

- Multicycle control unit that drives the 16-bit ALU's 4-bit aluOp and the datapath strobes.
- Fetches one 16-bit instruction per transaction and decodes it into aluOp, operand select and write/memory enables.
- Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK and uses the ALU isZero flag for branch resolution.
- Sits between instruction/data memory handshakes and the register file/ALU datapath.

---
 rtl/alu_control_fsm.sv | 192 +++++++++++++++++++
 tb/tb_alu_control_fsm.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_fsm.sv
// Multicycle control unit: fetches a 16-bit instruction, decodes it and sequences
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK, driving the ALU opcode and datapath strobes.
module alu_control_fsm #(
  parameter int MEM_TIMEOUT   = 255,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic        instrReq,
  input  logic        instrValid,
  input  logic [15:0] instrIn,
  input  logic        isZero,
  input  logic        memDone,
  output logic [3:0]  aluOp,
  output logic        aluSrcB,
  output logic        regWrite,
  output logic        memToReg,
  output logic        memRead,
  output logic        memWrite,
  output logic        pcWrite,
  output logic        pcSrc,
  output logic [15:0] irOut,
  output logic        halted,
  output logic        memError
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADDI = 4'hA;
  localparam logic [3:0] OP_LW   = 4'hB;
  localparam logic [3:0] OP_SW   = 4'hC;
  localparam logic [3:0] OP_BEQ  = 4'hD;
  localparam logic [3:0] OP_SLT  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LIMIT = TIMEOUT_WIDTH'(MEM_TIMEOUT);
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_ZERO  = '0;
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE   = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state_r;
  logic [TIMEOUT_WIDTH-1:0] count_r;
  logic [15:0]              ir_r;
  logic [3:0]               alu_op_r;
  logic                     alu_src_b_r;
  logic                     reg_write_r;
  logic                     mem_to_reg_r;
  logic                     mem_read_r;
  logic                     mem_write_r;
  logic                     mem_error_r;
  logic [3:0]               opcode_s;
  logic                     beq_taken_s;

  assign opcode_s = ir_r[15:12];

  // ALU code issued for an opcode; codes 1010..1101 can never come out of here.
  function automatic logic [3:0] alu_op_of(input logic [3:0] op);
    logic [3:0] code;
    case (op)
      OP_SLT:                code = 4'b1111;
      OP_BEQ:                code = 4'b0111;
      OP_ADDI, OP_LW, OP_SW: code = 4'b0000;
      OP_HALT:               code = 4'b0000;
      default:               code = op;
    endcase
    return code;
  endfunction

  function automatic logic uses_imm(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

  // Sequencer; datapath controls are registered on the transition into each state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= FETCH;
      count_r      <= CNT_ZERO;
      ir_r         <= 16'h0000;
      alu_op_r     <= 4'b0000;
      alu_src_b_r  <= 1'b0;
      reg_write_r  <= 1'b0;
      mem_to_reg_r <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_error_r  <= 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          if (instrValid) begin
            ir_r    <= instrIn;
            state_r <= DECODE;
          end
        end
        DECODE: begin
          if (opcode_s == OP_HALT) begin
            state_r <= HALT;
          end else begin
            alu_op_r    <= alu_op_of(opcode_s);
            alu_src_b_r <= uses_imm(opcode_s);
            state_r     <= EXECUTE;
          end
        end
        EXECUTE: begin
          if (opcode_s == OP_LW || opcode_s == OP_SW) begin
            mem_read_r  <= (opcode_s == OP_LW);
            mem_write_r <= (opcode_s == OP_SW);
            count_r     <= CNT_ZERO;
            state_r     <= MEM;
          end else if (opcode_s == OP_BEQ) begin
            alu_op_r    <= 4'b0000;
            alu_src_b_r <= 1'b0;
            state_r     <= FETCH;
          end else begin
            reg_write_r  <= 1'b1;
            mem_to_reg_r <= 1'b0;
            state_r      <= WRITEBACK;
          end
        end
        MEM: begin
          // memDone takes priority over a coincident timeout
          if (memDone) begin
            count_r     <= CNT_ZERO;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            if (opcode_s == OP_LW) begin
              reg_write_r  <= 1'b1;
              mem_to_reg_r <= 1'b1;
              state_r      <= WRITEBACK;
            end else begin
              alu_op_r    <= 4'b0000;
              alu_src_b_r <= 1'b0;
              state_r     <= FETCH;
            end
          end else if (count_r == CNT_LIMIT) begin
            count_r     <= CNT_ZERO;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            alu_op_r    <= 4'b0000;
            alu_src_b_r <= 1'b0;
            mem_error_r <= 1'b1;
            state_r     <= HALT;
          end else begin
            count_r <= count_r + CNT_ONE;
          end
        end
        WRITEBACK: begin
          reg_write_r  <= 1'b0;
          mem_to_reg_r <= 1'b0;
          alu_op_r     <= 4'b0000;
          alu_src_b_r  <= 1'b0;
          state_r      <= FETCH;
        end
        HALT: begin
          state_r <= HALT;
        end
        default: begin
          state_r <= FETCH;
        end
      endcase
    end
  end

  // pcWrite/pcSrc react to the fetch handshake and isZero within the cycle; reset masks them.
  always_comb begin
    beq_taken_s = 1'b0;
    if (state_r == EXECUTE && opcode_s == OP_BEQ) begin
      beq_taken_s = isZero;
    end else begin
      beq_taken_s = 1'b0;
    end
    instrReq = ~reset & (state_r == FETCH);
    pcWrite  = ~reset & (((state_r == FETCH) & instrValid) | beq_taken_s);
    pcSrc    = ~reset & beq_taken_s;
  end

  assign aluOp    = alu_op_r;
  assign aluSrcB  = alu_src_b_r;
  assign regWrite = reg_write_r;
  assign memToReg = mem_to_reg_r;
  assign memRead  = mem_read_r;
  assign memWrite = mem_write_r;
  assign irOut    = ir_r;
  assign halted   = (state_r == HALT);
  assign memError = mem_error_r;

endmodule

// File: tb/tb_alu_control_fsm.sv
// Randomised bench: a per-cycle reference trace is pushed by the stimulus process and
// compared against the DUT outputs by an independent monitor on the falling edge.
module tb_alu_control_fsm;

  localparam int MEM_T = 4;

  logic        clk;
  logic        reset;
  logic        instrReq;
  logic        instrValid;
  logic [15:0] instrIn;
  logic        isZero;
  logic        memDone;
  logic [3:0]  aluOp;
  logic        aluSrcB;
  logic        regWrite;
  logic        memToReg;
  logic        memRead;
  logic        memWrite;
  logic        pcWrite;
  logic        pcSrc;
  logic [15:0] irOut;
  logic        halted;
  logic        memError;

  alu_control_fsm #(.MEM_TIMEOUT(MEM_T), .TIMEOUT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .instrReq(instrReq), .instrValid(instrValid),
    .instrIn(instrIn), .isZero(isZero), .memDone(memDone), .aluOp(aluOp),
    .aluSrcB(aluSrcB), .regWrite(regWrite), .memToReg(memToReg), .memRead(memRead),
    .memWrite(memWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .irOut(irOut),
    .halted(halted), .memError(memError)
  );

  typedef struct packed {
    logic        req;
    logic        pcw;
    logic        pcs;
    logic [3:0]  op;
    logic        srcb;
    logic        rw;
    logic        m2r;
    logic        mr;
    logic        mw;
    logic        hlt;
    logic        merr;
    logic [15:0] ir;
  } out_t;

  out_t        exp_q[$];
  string       name_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] ir_m;
  logic        merr_m;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [15:0] rw16();
    return 16'($urandom);
  endfunction

  // Architectural view of the ALU code each instruction class asks for.
  function automatic logic [3:0] ref_op(input logic [3:0] op);
    if (op <= 4'd9) return op;
    if (op == 4'hE) return 4'hF;
    if (op == 4'hD) return 4'h7;
    return 4'h0;
  endfunction

  function automatic out_t base();
    out_t e;
    e = '0;
    e.ir = ir_m;
    e.merr = merr_m;
    return e;
  endfunction

  task automatic cyc(input logic r, input logic v, input logic [15:0] ins, input logic z,
                     input logic d, input out_t e, input string nm);
    @(posedge clk);
    #1;
    reset = r;
    instrValid = v;
    instrIn = ins;
    isZero = z;
    memDone = d;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic reset_cycle();
    out_t e;
    ir_m = 16'h0000;
    merr_m = 1'b0;
    e = base();
    cyc(1'b1, rb(), rw16(), rb(), rb(), e, "reset");
  endtask

  task automatic halt_cycles(input int n);
    out_t e;
    for (int i = 0; i < n; i++) begin
      e = base();
      e.hlt = 1'b1;
      cyc(1'b0, rb(), rw16(), rb(), rb(), e, "halt");
    end
  endtask

  // lat = MEM cycle on which memDone arrives (0 = never); abort = MEM cycle to reset in (0 = none)
  task automatic run_instr(input logic [15:0] instr, input int waits, input logic zero,
                           input int lat, input int abort);
    out_t e;
    logic [3:0] op;
    int limit;
    op = instr[15:12];
    for (int i = 0; i < waits; i++) begin
      e = base();
      e.req = 1'b1;
      cyc(1'b0, 1'b0, rw16(), rb(), rb(), e, "fetch_wait");
    end
    e = base();
    e.req = 1'b1;
    e.pcw = 1'b1;
    cyc(1'b0, 1'b1, instr, rb(), rb(), e, "accept");
    ir_m = instr;
    e = base();
    cyc(1'b0, rb(), rw16(), rb(), rb(), e, "decode");
    if (op == 4'hF) begin
      halt_cycles(3);
      return;
    end
    e = base();
    e.op = ref_op(op);
    e.srcb = (op == 4'hA) || (op == 4'hB) || (op == 4'hC);
    if (op == 4'hD) begin
      e.pcw = zero;
      e.pcs = zero;
      cyc(1'b0, rb(), rw16(), zero, rb(), e, "exec_beq");
      return;
    end
    cyc(1'b0, rb(), rw16(), rb(), rb(), e, "execute");
    if (op == 4'hB || op == 4'hC) begin
      e.mr = (op == 4'hB);
      e.mw = (op == 4'hC);
      limit = (lat == 0) ? MEM_T + 1 : lat;
      for (int i = 0; i < limit; i++) begin
        if (abort > 0 && i == abort) begin
          reset_cycle();
          return;
        end
        cyc(1'b0, rb(), rw16(), rb(), (lat != 0) && (i == lat - 1), e, "mem");
      end
      if (lat == 0) begin
        merr_m = 1'b1;
        halt_cycles(3);
        return;
      end
      e.mr = 1'b0;
      e.mw = 1'b0;
      if (op == 4'hC) return;
    end
    e.rw = 1'b1;
    e.m2r = (op == 4'hB);
    cyc(1'b0, rb(), rw16(), rb(), rb(), e, "writeback");
  endtask

  // Monitor: compares whatever the DUT shows against the oldest pending expectation.
  always @(negedge clk) begin
    out_t a;
    out_t e;
    string nm;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      a = '{instrReq, pcWrite, pcSrc, aluOp, aluSrcB, regWrite, memToReg,
            memRead, memWrite, halted, memError, irOut};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
      end
    end
  end

  initial begin
    logic [3:0] sweep [11];
    logic [3:0] op;
    reset = 1'b1;
    instrValid = 1'b0;
    instrIn = 16'h0000;
    isZero = 1'b0;
    memDone = 1'b0;
    ir_m = 16'h0000;
    merr_m = 1'b0;
    reset_cycle();
    reset_cycle();

    run_instr(16'h0123, 0, 1'b0, 0, 0);
    sweep = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hE};
    for (int i = 0; i < 11; i++) begin
      run_instr({sweep[i], 12'($urandom)}, $urandom_range(0, 1), rb(), 0, 0);
    end
    run_instr(16'hB215, 0, 1'b0, 3, 0);
    run_instr(16'hD012, 0, 1'b1, 0, 0);
    run_instr(16'hD012, 0, 1'b0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 14));
      run_instr({op, 12'($urandom)}, $urandom_range(0, 2), rb(), $urandom_range(1, 4), 0);
    end

    run_instr(16'hC000, 0, 1'b0, 0, 0);
    reset_cycle();
    run_instr(16'hF000, 1, 1'b0, 0, 0);
    reset_cycle();
    run_instr(16'hB215, 0, 1'b0, 0, 2);
    run_instr(16'h0123, 0, 1'b0, 0, 0);
    run_instr(16'hC3A7, 1, 1'b0, MEM_T + 1, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
